// File: rtl/rb_pkg.sv
// Shared definitions for the multi-lane parity-checked FIFO.
// Latency: n/a (package). Backpressure: n/a.
// Holds default geometry constants and the per-byte even-parity check.
package rb_pkg;

  localparam int RB_LANES    = 2;
  localparam int RB_LANE_W   = 64;
  localparam int RB_DEPTH    = 512;
  localparam int RB_AF_LEVEL = 384;

  // Even parity over 8 data bits plus their parity bit; 1 means the byte is bad.
  function automatic logic byte_par_err(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/rb_lane_check.sv
// Byte-parity checker for one data lane.
// Latency: combinational. Backpressure: none.
// Ports: dat (lane data), par (one even-parity bit per byte), err (any byte bad).
module rb_lane_check
  import rb_pkg::*;
#(
  parameter int LANE_W = RB_LANE_W
) (
  input  logic [LANE_W-1:0]   dat,
  input  logic [LANE_W/8-1:0] par,
  output logic                err
);

  always_comb begin
    err = 1'b0;
    for (int b = 0; b < LANE_W/8; b++) begin
      err = err | byte_par_err(dat[b*8 +: 8], par[b]);
    end
  end

endmodule

// File: rtl/rb_multilane_fifo.sv
// First-word-fall-through multi-lane FIFO; parity is checked on write and stored per entry.
// Latency: a push in cycle N is visible at the head in cycle N+1.
// Backpressure: Full (Count >= AF_LEVEL) asks the writer to stop; pushes at DEPTH without a pop are dropped and set sticky Overflow.
// Ports: Clock/Reset (sync, active-high); MD/MP/WRen write side; RD/ErrLane/ParityError/RDen/Empty read side;
//        Flush discards contents; Count occupancy; ErrCount saturating count of errored words popped.
module rb_multilane_fifo
  import rb_pkg::*;
#(
  parameter int LANES    = RB_LANES,
  parameter int LANE_W   = RB_LANE_W,
  parameter int DEPTH    = RB_DEPTH,
  parameter int AF_LEVEL = RB_AF_LEVEL
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [LANES*LANE_W-1:0]     MD,
  input  logic [LANES*LANE_W/8-1:0]   MP,
  input  logic                        WRen,
  output logic                        Full,
  output logic                        Overflow,
  input  logic                        Flush,
  output logic [LANES*LANE_W-1:0]     RD,
  output logic [LANES-1:0]            ErrLane,
  output logic                        ParityError,
  input  logic                        RDen,
  output logic                        Empty,
  output logic [$clog2(DEPTH):0]      Count,
  output logic [15:0]                 ErrCount
);

  localparam int DW = LANES*LANE_W;
  localparam int EW = DW + LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    wr_word, ram_q, byp_dat, head;
  logic [LANES-1:0] wr_err;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr_nxt;
  logic [CW-1:0]    count_q;
  logic [15:0]      err_cnt_q;
  logic             ovf_q, byp_q, live, empty, push, pop;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rb_lane_check #(.LANE_W(LANE_W)) u_chk (
      .dat (MD[k*LANE_W +: LANE_W]),
      .par (MP[k*(LANE_W/8) +: LANE_W/8]),
      .err (wr_err[k])
    );
  end

  assign wr_word = {wr_err, MD};
  assign live    = !Reset && !Flush;
  assign empty   = (count_q == '0);
  assign pop     = live && RDen && !empty;
  // A pop frees a slot in the same cycle, so a push at DEPTH is still accepted.
  assign push    = live && WRen && ((count_q != DEPTH_C) || pop);

  // Address the RAM with where the head will be next cycle, so the registered
  // read lands exactly when the head advances.
  assign rd_addr_nxt = live ? (rd_ptr + AW'(pop)) : '0;

  // Plain simple-dual-port RAM with registered read; no reset on the array.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= wr_word;
    ram_q <= mem[rd_addr_nxt];
  end

  // The RAM returns old data when the slot being read is written in the same
  // cycle (push into an empty queue, or push+pop at Count=1); forward it.
  always_ff @(posedge Clock) begin
    byp_q   <= push && (wr_ptr == rd_addr_nxt);
    byp_dat <= wr_word;
  end

  assign head = byp_q ? byp_dat : ram_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (Flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (WRen && !push) ovf_q <= 1'b1;
      if (pop && ParityError && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign RD          = head[DW-1:0];
  // Masked while empty so the error flags never reflect a stale RAM word.
  assign ErrLane     = empty ? '0 : head[EW-1:DW];
  assign ParityError = |ErrLane;
  assign Empty       = empty;
  assign Count       = count_q;
  assign Full        = (count_q >= AF_C);
  assign Overflow    = ovf_q;
  assign ErrCount    = err_cnt_q;

endmodule

// File: doc/rb_multilane_fifo.md
RB_MULTILANE_FIFO -- requirements
Module: rb_multilane_fifo

Interface
REQ-001 SHALL have parameter LANES, default 2: number of data lanes.
REQ-002 SHALL have parameter LANE_W, default 64: bits per lane, multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 512: entries, power of 2, >=4.
REQ-004 SHALL have parameter AF_LEVEL, default 384: almost-full threshold, 1..DEPTH.
REQ-005 SHALL have one clock and one reset: reset is synchronous and active-high (ports Clock, Reset as named in the codebase).
REQ-006 Ports SHALL be:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous active-high reset
- MD  in  LANES*LANE_W  write data; lane k = MD[k*LANE_W +: LANE_W]
- MP  in  LANES*LANE_W/8  even-parity bit per byte of MD
- WRen  in  1  push request
- Full  out  1  almost-full, writer must stop
- Overflow  out  1  sticky: push dropped
- Flush  in  1  discard all entries
- RD  out  LANES*LANE_W  head-of-queue data
- ErrLane  out  LANES  per-lane parity error of head entry
- ParityError  out  1  OR of ErrLane
- RDen  in  1  pop request
- Empty  out  1  no valid head entry
- Count  out  log2(DEPTH)+1  occupancy
- ErrCount  out  16  saturating count of popped errored words

Function
REQ-007 SHALL be first-word-fall-through: RD, ErrLane, ParityError valid whenever Empty=0.
REQ-008 SHALL accept a push when WRen=1 and (Count<DEPTH or a pop occurs the same cycle); an entry pushed in cycle N appears at head no earlier than cycle N+1.
REQ-009 SHALL compute parity at write time: ErrLane bit k set when any byte of lane k has odd parity over data bit plus its MP bit; stored with the entry.
REQ-010 SHALL pop when RDen=1 and Empty=0; RDen with Empty=1 is ignored, no state change.
REQ-011 SHALL update Count by +1 push only, -1 pop only, unchanged on both or neither.
REQ-012 Full SHALL equal (Count >= AF_LEVEL), derived from the registered Count.
REQ-013 WRen=1 with Count=DEPTH and no pop SHALL drop data and set Overflow; Overflow clears only on Reset.
REQ-014 ErrCount SHALL increment on each pop with ParityError=1; SHALL saturate at 16'hFFFF.
REQ-015 Flush=1 SHALL, next cycle, give Count=0, Empty=1; WRen/RDen in the Flush cycle ignored; ErrCount, Overflow unaffected.
REQ-016 Read/write pointers SHALL wrap modulo DEPTH without a gap.
REQ-017 Empty SHALL equal (Count=0) in all steady states.

Reset
REQ-018 Reset=1 at a rising edge SHALL give next cycle: Count=0, Empty=1, Full=0, Overflow=0, ErrCount=0, ErrLane=0, ParityError=0; RD don't-care.
REQ-019 Reset SHALL override Flush, WRen, RDen; asserted mid-stream it discards all contents.
REQ-020 Storage array contents SHALL need no reset.

Structure
REQ-021 Shared package rb_pkg SHALL hold a per-byte parity function and default parameter constants.
REQ-022 Per-lane byte-parity check SHALL be sub-module rb_lane_check (LANE_W data + LANE_W/8 parity in, 1-bit error out), instantiated LANES times.
REQ-023 Storage SHALL be a single simple-dual-port array of DEPTH x (LANES*LANE_W + LANES) bits, inferable as block RAM.

Verification
REQ-024 Reset, push 3 words good parity, pop 3 -> same order, ParityError=0, Empty=1 after, Count=0.
REQ-025 Push 384 words with RDen=0 -> Full=1 when Count=384; continue to 512 then one more WRen -> Overflow=1, Count=512.
REQ-026 Count=512, WRen=1 and RDen=1 same cycle -> both accepted, Count stays 512, Overflow=0.
REQ-027 Push word with byte 0 of lane 1 parity flipped -> at head ErrLane=2'b10, ParityError=1; pop -> ErrCount=1.
REQ-028 Count=10, ErrCount=3, Flush=1 with WRen=1 -> next cycle Count=0, Empty=1, ErrCount=3; next push at head one cycle later.
REQ-029 Wrap: 1000 random push/pop cycles vs reference queue -> data and ErrLane match; Reset mid-run -> all outputs at reset values next cycle.
